// File: rtl/seq2b_pkg.sv
// Shared types and helpers for the 2-bit sequence game and its autoplayer.
package seq2b_pkg;

    localparam int DEPTH = 8;

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_PRESS,
        ST_RELEASE,
        ST_DONE
    } state_e;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic sym_t enc_sym(input logic [3:0] v);
        sym_t s;
        s = 2'd0;
        if (v[1]) s = 2'd1;
        if (v[2]) s = 2'd2;
        if (v[3]) s = 2'd3;
        return s;
    endfunction

    function automatic logic [3:0] dec_sym(input sym_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/seq2b_symbuf.sv
// Symbol register file: append at count, random read at index.
module seq2b_symbuf
    import seq2b_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       wr_i,
    input  sym_t       wsym_i,
    input  logic [3:0] ridx_i,
    output sym_t       rsym_o,
    output logic [3:0] count_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);

    sym_t       mem_q [DEPTH];
    logic [3:0] count_q, count_d;
    logic       full;
    logic       do_wr;

    assign full  = (count_q == 4'(DEPTH));
    assign do_wr = wr_i && !full && !clr_i;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (do_wr) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            count_q <= count_d;
            if (do_wr) begin
                mem_q[count_q[AW-1:0]] <= wsym_i;
            end
        end
    end

    // Reads past the last entry return 0 rather than aliasing.
    assign rsym_o  = (ridx_i < 4'(DEPTH)) ? mem_q[ridx_i[AW-1:0]] : 2'd0;
    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/seq2b_autoplayer.sv
// Autoplayer: records the game's light sequence, then replays it as button presses.
module seq2b_autoplayer
    import seq2b_pkg::*;
#(
    parameter int QUIET_CYC = 6,
    parameter int PRESS_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] l,
    input  logic       win,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] count
);

    localparam int TMAX = (QUIET_CYC > PRESS_CYC)
                        ? ((QUIET_CYC > GAP_CYC) ? QUIET_CYC : GAP_CYC)
                        : ((PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC);
    localparam int CW   = $clog2(TMAX + 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    lprev_q;
    logic          err_q, err_d;
    logic [3:0]    b_q, b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          lit_edge;
    logic          legal;
    logic          wr;
    logic          clr;
    logic          full;
    sym_t          rsym;
    logic [3:0]    cnt;

    assign lit_edge = (lprev_q == 4'd0) && (l != 4'd0);
    assign legal    = is_onehot(l);

    seq2b_symbuf u_buf (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (clr),
        .wr_i    (wr),
        .wsym_i  (enc_sym(l)),
        .ridx_i  (idx_d),
        .rsym_o  (rsym),
        .count_o (cnt),
        .full_o  (full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qcnt_d  = qcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        wr      = 1'b0;
        clr     = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (win && state_q != ST_IDLE) begin
            state_d = ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_LISTEN;
                    clr     = 1'b1;
                    idx_d   = 4'd0;
                    qcnt_d  = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                end
                ST_LISTEN: begin
                    wr = lit_edge && legal;
                    if (lit_edge && (!legal || full)) begin
                        err_d = 1'b1;
                    end
                    if (l != 4'd0) begin
                        qcnt_d = '0;
                    end else if (qcnt_q != CW'(QUIET_CYC)) begin
                        qcnt_d = qcnt_q + 1'b1;
                    end
                    // Leading darkness before any symbol never starts a replay.
                    if (l == 4'd0 && qcnt_d == CW'(QUIET_CYC) && cnt != 4'd0) begin
                        state_d = ST_PRESS;
                        idx_d   = 4'd0;
                        tcnt_d  = '0;
                    end
                end
                ST_PRESS: begin
                    if (tcnt_q == CW'(PRESS_CYC - 1)) begin
                        state_d = ST_RELEASE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (tcnt_q == CW'(GAP_CYC - 1)) begin
                        tcnt_d = '0;
                        idx_d  = idx_q + 4'd1;
                        if (idx_q + 4'd1 == cnt) begin
                            state_d = ST_LISTEN;
                            clr     = 1'b1;
                            qcnt_d  = '0;
                        end else begin
                            state_d = ST_PRESS;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d = (state_d == ST_LISTEN) || (state_d == ST_PRESS)
              || (state_d == ST_RELEASE);
        done_d = (state_d == ST_DONE);
        b_d    = (state_d == ST_PRESS) ? dec_sym(rsym) : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            qcnt_q  <= '0;
            tcnt_q  <= '0;
            lprev_q <= 4'd0;
            err_q   <= 1'b0;
            b_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qcnt_q  <= qcnt_d;
            tcnt_q  <= tcnt_d;
            lprev_q <= l;
            err_q   <= err_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign b     = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign count = cnt;

endmodule

// File: tb/tb_seq2b_autoplayer.sv
// Randomized bench for seq2b_autoplayer against a queue-based replay model.
module tb_seq2b_autoplayer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] l;
    logic       win;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] exp_q[$];
    bit         merr;

    seq2b_autoplayer dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .l      (l),
        .win    (win),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        enable = 1'b0;
        l      = 4'd0;
        win    = 1'b0;
        tick();
        chk("idle_b", b, 0);
        chk("idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        chk("arm_busy", busy, 1);
        exp_q.delete();
        merr = 1'b0;
    endtask

    // Light one value for hold cycles then darkness for gap cycles.
    task automatic feed(input logic [3:0] v, input int hold, input int gap);
        if ($countones(v) == 1) begin
            if (exp_q.size() < 8) exp_q.push_back(v);
            else merr = 1'b1;
        end else begin
            merr = 1'b1;
        end
        l = v;
        repeat (hold) tick();
        l = 4'd0;
        repeat (gap) tick();
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (b == 4'd0 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_replay();
        int lat;
        if (exp_q.size() == 0) begin
            repeat (10) tick();
            chk("nopress_b", b, 0);
            chk("nopress_cnt", count, 0);
            chk("nopress_err", err, merr);
        end else begin
            wait_b(lat);
            chk("quiet_lat", lat, 6);
            chk("count", count, exp_q.size());
            chk("err", err, merr);
            chk("busy", busy, 1);
            foreach (exp_q[i]) begin
                chk("press", b, exp_q[i]);
                tick();
                chk("press", b, exp_q[i]);
                tick();
                chk("gap", b, 0);
                tick();
                chk("gap", b, 0);
                tick();
            end
            chk("relisten_cnt", count, 0);
            chk("relisten_busy", busy, 1);
            chk("relisten_done", done, 0);
        end
    endtask

    function automatic logic [3:0] rand_light(input bit allow_bad);
        logic [3:0] v;
        if (allow_bad && $urandom_range(0, 5) == 0) begin
            v = 4'($urandom_range(3, 15));
            while ($countones(v) < 2) v = 4'($urandom_range(3, 15));
        end else begin
            v = 4'b0001 << $urandom_range(0, 3);
        end
        return v;
    endfunction

    initial begin
        int lat;
        int n;
        reset  = 1'b1;
        enable = 1'b0;
        l      = 4'd0;
        win    = 1'b0;
        repeat (3) tick();
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // basic replay
        restart();
        feed(4'b0001, 2, 2);
        feed(4'b0100, 2, 2);
        feed(4'b1000, 2, 0);
        check_replay();

        // one long light is a single symbol
        restart();
        feed(4'b0010, 10, 0);
        check_replay();

        // illegal edge between two valid symbols
        restart();
        feed(4'b0001, 2, 2);
        feed(4'b0110, 2, 2);
        feed(4'b1000, 2, 0);
        check_replay();

        // overflow: nine valid symbols
        restart();
        for (int i = 0; i < 9; i++) begin
            feed(rand_light(1'b0), $urandom_range(1, 3),
                 (i == 8) ? 0 : $urandom_range(1, 4));
        end
        check_replay();

        // random levels
        for (int k = 0; k < 8; k++) begin
            restart();
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                feed(rand_light(1'b1), $urandom_range(1, 4),
                     (i == n - 1) ? 0 : $urandom_range(1, 4));
            end
            check_replay();
        end

        // consecutive levels without re-arming: sequence is re-recorded
        restart();
        feed(4'b0100, 2, 0);
        check_replay();
        exp_q.delete();
        feed(4'b0100, 3, 3);
        feed(4'b0001, 1, 0);
        check_replay();

        // win during the second press
        restart();
        feed(4'b0001, 2, 2);
        feed(4'b0010, 2, 2);
        feed(4'b0100, 2, 0);
        wait_b(lat);
        chk("win_lat", lat, 6);
        repeat (4) tick();
        chk("win_press2", b, 4'b0010);
        win = 1'b1;
        tick();
        chk("win_b", b, 0);
        chk("win_done", done, 1);
        chk("win_busy", busy, 0);
        win = 1'b0;
        tick();
        chk("win_hold", done, 1);
        enable = 1'b0;
        tick();
        chk("win_idle_done", done, 0);
        chk("win_idle_busy", busy, 0);

        // enable dropped mid-press
        restart();
        feed(4'b1000, 2, 0);
        wait_b(lat);
        chk("en_press", b, 4'b1000);
        enable = 1'b0;
        tick();
        chk("en_b", b, 0);
        chk("en_busy", busy, 0);

        // asynchronous reset while pressing
        restart();
        feed(4'b0110, 2, 2);
        feed(4'b0100, 2, 0);
        wait_b(lat);
        chk("ar_press", b, 4'b0100);
        chk("ar_err_pre", err, 1);
        chk("ar_cnt_pre", count, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_b", b, 0);
        chk("ar_count", count, 0);
        chk("ar_err", err, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ar_rearm", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq2b_autoplayer.md
Name: seq2b_autoplayer

Overview:
- Automatic player for the 2-bit, 8-level sequence memory game; it sits on the opposite side of the game's light/button interface.
- Watches the game's one-hot lights `l[3:0]`, records each displayed 2-bit symbol into an 8-entry buffer, detects the end of the display phase, then replays the sequence as one-hot button presses on `b[3:0]`.
- Used for hands-off regression of the game and for demo mode; stops when the game raises `win`.

Parameters:
- QUIET_CYC, 6: consecutive cycles of `l==0` (after at least one symbol) that mark the end of the display phase.
- PRESS_CYC, 2: cycles each button is held high.
- GAP_CYC, 2: cycles `b` is held at 0 between presses.
- DEPTH, 8: symbol buffer depth, one entry per game level.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  player armed; when low, the block idles with `b=0`.
- l  input  4  game lights; legal values are 0 or one-hot.
- win  input  1  game win flag.
- b  output  4  button drive, one-hot or 0, registered.
- busy  output  1  high in LISTEN, PRESS or RELEASE.
- done  output  1  high in DONE.
- err  output  1  sticky: illegal light pattern or buffer overflow seen.
- count  output  4  symbols currently recorded, 0..8.

Behaviour:
- Reset values: `b=0`, `busy=0`, `done=0`, `err=0`, `count=0`, state IDLE, index 0, quiet counter 0, previous-light register 0. All outputs are registered.
- Symbol encoding:
  - `l[0]` → 0, `l[1]` → 1, `l[2]` → 2, `l[3]` → 3.
  - Replay drives `b = 1<<sym`.
- IDLE: if `enable`, go to LISTEN next cycle and clear count, index, quiet counter and err.
- LISTEN:
  - Capture a symbol when the previous cycle's `l` was 0 and the current `l` is nonzero one-hot: store at `buf[count]`, then `count+1`. A light held high for many cycles is one symbol.
  - Illegal light pattern (nonzero, not one-hot) on a 0→nonzero edge: set err, store nothing, count unchanged.
  - Overflow: capture edge with `count==DEPTH` sets err, store nothing, count stays 8.
  - Quiet counter: increments while `l==0`, clears on any nonzero `l`, saturates at QUIET_CYC.
  - When the quiet counter reaches QUIET_CYC with `count>0`: go to PRESS with index 0. With `count==0`, stay in LISTEN; the initial dark period does not count.
- PRESS:
  - `b=onehot(buf[index])` from the first cycle in PRESS, held for exactly PRESS_CYC cycles, then RELEASE.
  - `l` is ignored.
- RELEASE:
  - `b=0` for exactly GAP_CYC cycles.
  - Then `index+1`. If the new index equals count, go to LISTEN and clear count and quiet counter, so the next level's full sequence is re-recorded. Otherwise go to PRESS.
- DONE: `b=0`, `done=1`; hold until `enable=0`, then IDLE.
- Priority, evaluated each cycle: reset > (`enable==0` → IDLE) > (`win` in any non-IDLE state → DONE) > normal transitions.
- Aborts:
  - Dropping `enable` mid-press forces `b=0` on the next edge.
  - Reset mid-press forces `b=0` immediately, since reset is asynchronous.
- Counters are sized to hold max(QUIET_CYC, PRESS_CYC, GAP_CYC). Index and count are 4 bits and never wrap.
- `busy` = (state ∈ {LISTEN, PRESS, RELEASE}).
- Latency from the last quiet cycle to `b` high: 1 clock.

Decomposition:
- Shared package `seq2b_pkg` holds:
  - state enum: IDLE, LISTEN, PRESS, RELEASE, DONE;
  - symbol type (2 bits);
  - DEPTH = 8;
  - encode/decode functions for one-hot ↔ symbol, which the game RTL also uses.
- One natural sub-module, `seq2b_symbuf`: 8×2-bit register file with write-at-count and read-at-index, owning the count and overflow flag.
- The FSM and timers stay in the top module.

Test Plan:
- Basic replay:
  - Stimulus: `enable=1`; drive `l` = 0001, 0, 0100, 0, 1000 (2 cycles each, 0 gaps of 2), then 0 for 6 cycles.
  - Response: `count=3`; `b` = 0001 ×2, 0 ×2, 0100 ×2, 0 ×2, 1000 ×2, 0 ×2; back in LISTEN with `count=0`.
- Held light:
  - Stimulus: `l=0010` held 10 cycles, then quiet.
  - Response: exactly one symbol (`count=1`); replay `b=0010` for 2 cycles.
- Illegal pattern:
  - Stimulus: `l=0110` edge among valid symbols 0001 and 1000.
  - Response: `err=1`, `count=2`, replay 0001 then 1000 only.
- Overflow:
  - Stimulus: 9 valid symbols.
  - Response: `count=8`, `err=1`; replay covers the first 8 only.
- Win:
  - Stimulus: assert `win` during the second PRESS.
  - Response: next cycle `b=0`, `done=1`, `busy=0`; `enable=0` → IDLE with `done=0`.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously while `b=0100`.
  - Response: `b=0`, `count=0`, `err=0` immediately, with no clock edge required.
